// File: rtl/output_save.sv
// Buffer-to-DRAM store engine: decodes a save instruction, streams buffer entries as AXI4-Stream beats, and pulses ap_done once the write master finishes.
// Reads are credit-limited so that reads in flight plus FIFO occupancy never exceed FIFO_DEPTH.
module output_save #(
  parameter int SAVE_INST_LENGTH   = 96,
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int C_XFER_SIZE_WIDTH  = 32,
  parameter int RD_LATENCY         = 1,
  parameter int FIFO_DEPTH         = 4
) (
  input  logic                          kernel_clk,
  input  logic                          kernel_rst,
  input  logic                          ap_start,
  output logic                          ap_done,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_addr_offset,
  input  logic [SAVE_INST_LENGTH-1:0]   ctrl_instruction,
  output logic                          save_read_buffer_en,
  output logic [8:0]                    save_read_buffer_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] save_read_buffer_data,
  output logic                          wr_start,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] wr_addr,
  output logic [C_XFER_SIZE_WIDTH-1:0]  wr_size,
  input  logic                          wr_done,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [C_M_AXI_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                          m_axis_tlast
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_RUN, S_WAIT_DONE, S_DONE} state_t;

  state_t                          r_state, w_next;
  logic [8:0]                      r_buf_start, r_count, r_issued, r_popped;
  logic [15:0]                     r_dram_start, r_len;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   r_offset, r_wr_addr;
  logic [C_XFER_SIZE_WIDTH-1:0]    r_wr_size;
  logic                            r_wr_start, r_done_seen;
  logic [RD_LATENCY-1:0]           r_rd_pipe;
  logic [C_M_AXI_DATA_WIDTH-1:0]   r_mem [FIFO_DEPTH];
  logic [PW-1:0]                   r_wr_ptr, r_rd_ptr;
  logic [OW-1:0]                   r_occ;
  logic                            w_rd_en, w_tvalid, w_pop, w_push, w_last;
  logic                            w_unused;

  assign w_unused = ^{ctrl_instruction[31:0], ctrl_instruction[47:41], ctrl_instruction[63:57]};

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_tvalid = (r_occ != '0);
  assign w_pop    = w_tvalid && m_axis_tready;
  assign w_push   = r_rd_pipe[RD_LATENCY-1];
  assign w_last   = w_tvalid && (r_popped == r_count - 9'd1);

  always_comb begin
    w_next  = r_state;
    w_rd_en = 1'b0;
    case (r_state)
      S_IDLE:      if (ap_start) w_next = S_DECODE;
      S_DECODE:    w_next = S_RUN;
      S_RUN: begin
        // A zero-count job idles here for one cycle, with no wr_start, before completing.
        if (r_count == 9'd0) w_next = S_DONE;
        else begin
          w_rd_en = (r_issued < r_count) && (($countones(r_rd_pipe) + int'(r_occ)) < FIFO_DEPTH);
          if (w_pop && w_last) w_next = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: if (wr_done || r_done_seen) w_next = S_DONE;
      S_DONE:      w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge kernel_clk or posedge kernel_rst) begin
    if (kernel_rst) begin
      r_state      <= S_IDLE;
      r_buf_start  <= '0;
      r_count      <= '0;
      r_dram_start <= '0;
      r_len        <= '0;
      r_offset     <= '0;
      r_wr_addr    <= '0;
      r_wr_size    <= '0;
      r_wr_start   <= 1'b0;
      r_done_seen  <= 1'b0;
      r_issued     <= '0;
      r_popped     <= '0;
      r_rd_pipe    <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_occ        <= '0;
    end else begin
      r_state    <= w_next;
      r_wr_start <= (r_state == S_DECODE) && (r_count != 9'd0);
      if (r_state == S_IDLE && ap_start) begin
        r_buf_start  <= ctrl_instruction[40:32];
        r_count      <= ctrl_instruction[56:48];
        r_dram_start <= ctrl_instruction[79:64];
        r_len        <= ctrl_instruction[95:80];
        r_offset     <= ctrl_addr_offset;
      end
      if (r_state == S_DECODE) begin
        r_wr_addr   <= r_offset + {{(C_M_AXI_ADDR_WIDTH-16){1'b0}}, r_dram_start};
        r_wr_size   <= {{(C_XFER_SIZE_WIDTH-16){1'b0}}, r_len};
        r_issued    <= '0;
        r_popped    <= '0;
        r_rd_pipe   <= '0;
        r_wr_ptr    <= '0;
        r_rd_ptr    <= '0;
        r_occ       <= '0;
        r_done_seen <= 1'b0;
      end else begin
        if (w_rd_en) r_issued <= r_issued + 9'd1;
        if (w_pop) begin
          r_popped <= r_popped + 9'd1;
          r_rd_ptr <= ptr_inc(r_rd_ptr);
        end
        if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
        if (w_push && !w_pop) r_occ <= r_occ + 1'b1;
        else if (!w_push && w_pop) r_occ <= r_occ - 1'b1;
        r_rd_pipe[0] <= w_rd_en;
        for (int i = 1; i < RD_LATENCY; i++) r_rd_pipe[i] <= r_rd_pipe[i-1];
        // Sticky so a completion reported while beats are still streaming is not lost.
        if (wr_done && ((r_state == S_RUN && !r_wr_start) || r_state == S_WAIT_DONE))
          r_done_seen <= 1'b1;
      end
    end
  end

  always_ff @(posedge kernel_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= save_read_buffer_data;
  end

  assign ap_done               = (r_state == S_DONE);
  assign wr_start              = r_wr_start;
  assign wr_addr               = r_wr_addr;
  assign wr_size               = r_wr_size;
  assign save_read_buffer_en   = w_rd_en;
  assign save_read_buffer_addr = w_rd_en ? (r_buf_start + r_issued) : 9'd0;
  assign m_axis_tvalid         = w_tvalid;
  assign m_axis_tdata          = w_tvalid ? r_mem[r_rd_ptr] : '0;
  assign m_axis_tlast          = w_last;

endmodule
